hamming_decoder: RTL and testbench

//   Single-error-correcting Hamming [7,4] decoder. Registers a 7-bit codeword every clock.

---
 rtl/hamming74_pkg.sv | 32 +++
 rtl/hamming74_syndrome.sv | 12 +
 rtl/hamming_decoder.sv | 70 +++++++
 tb/tb_hamming_decoder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hamming74_pkg.sv
// Hamming [7,4] shared definitions: word types, bit positions and the
// pure syndrome/data-extraction helpers used by encoder and decoder.
package hamming74_pkg;

  typedef logic [2:0] syndrome_t;
  typedef logic [6:0] codeword_t;
  typedef logic [3:0] data_t;

  // Codeword index of each Hamming position (index = position - 1)
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D0 = 2;
  localparam int P4 = 3;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  // Each syndrome bit covers the positions whose number has that bit set
  function automatic syndrome_t calc_syndrome(codeword_t c);
    return {c[P4] ^ c[D1] ^ c[D2] ^ c[D3],
            c[P2] ^ c[D0] ^ c[D2] ^ c[D3],
            c[P1] ^ c[D0] ^ c[D1] ^ c[D3]};
  endfunction

  // Data word is {pos7, pos6, pos5, pos3}
  function automatic data_t extract_data(codeword_t c);
    return {c[D3], c[D2], c[D1], c[D0]};
  endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// Combinational Hamming [7,4] syndrome generator. Shared between the
// decoder and the encoder-side self-check.
module hamming74_syndrome
  import hamming74_pkg::*;
(
  input  logic [6:0] codeword_i,
  output logic [2:0] syndrome_o
);

  assign syndrome_o = calc_syndrome(codeword_t'(codeword_i));

endmodule

// File: rtl/hamming_decoder.sv
// Hamming [7,4] single-error-correcting decoder, one-cycle latency.
// Optional feature: define HAMMING_ERR_COUNT_EN to add a saturating
// 16-bit count of edges that saw a non-zero syndrome (err_count port).
module hamming_decoder
  import hamming74_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  codeword,
  output logic [2:0]  syndrome,
  output logic [3:0]  data
`ifdef HAMMING_ERR_COUNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  syndrome_t syn;
  codeword_t flip_mask;
  codeword_t corrected;
  syndrome_t syndrome_q, syndrome_d;
  data_t     data_q, data_d;

  hamming74_syndrome u_syndrome (
    .codeword_i (codeword),
    .syndrome_o (syn)
  );

  // Flip the bit the syndrome points at; syndrome 0 means leave word alone
  always_comb begin
    flip_mask = '0;
    if (syn != 3'd0) flip_mask = codeword_t'(7'b1 << (syn - 3'd1));
    corrected  = codeword ^ flip_mask;
    syndrome_d = syn;
    data_d     = extract_data(corrected);
  end

  // Output registers; reset wins over the decode of the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syndrome_q <= '0;
      data_q     <= '0;
    end else begin
      syndrome_q <= syndrome_d;
      data_q     <= data_d;
    end
  end

  assign syndrome = syndrome_q;
  assign data     = data_q;

`ifdef HAMMING_ERR_COUNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count decoded errors, holding at all-ones instead of wrapping
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (syn != 3'd0 && err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Counter register, aligned with the syndrome register
  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Self-checking bench for hamming_decoder: directed table, reset corner
// cases, exhaustive single-error sweep and random words vs. a positional model.
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] codeword = '0;
  logic [2:0] syndrome;
  logic [3:0] data;
`ifdef HAMMING_ERR_COUNT_EN
  logic [15:0] err_count;
  int          exp_cnt = 0;
`endif

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  hamming_decoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .codeword (codeword),
    .syndrome (syndrome),
    .data     (data)
`ifdef HAMMING_ERR_COUNT_EN
    ,
    .err_count(err_count)
`endif
  );

  // Reference: syndrome is the XOR of the position numbers of all set bits
  function automatic logic [2:0] ref_syn(logic [6:0] c);
    int s = 0;
    for (int pos = 1; pos <= 7; pos++) if (c[pos-1]) s = s ^ pos;
    return 3'(s);
  endfunction

  function automatic logic [3:0] ref_data(logic [6:0] c);
    int s = int'(ref_syn(c));
    logic [6:0] w = c;
    if (s != 0) w[s-1] = ~w[s-1];
    return {w[6], w[5], w[4], w[2]};
  endfunction

  // Encoder: data at positions 3,5,6,7; parity p chosen so positions with bit p set XOR to 0
  function automatic logic [6:0] ref_encode(logic [3:0] d);
    logic [6:0] w = '0;
    int dpos[4] = '{3, 5, 6, 7};
    for (int i = 0; i < 4; i++) w[dpos[i]-1] = d[i];
    for (int p = 1; p <= 4; p = p * 2) begin
      logic par = 1'b0;
      for (int pos = 1; pos <= 7; pos++)
        if ((pos & p) != 0 && pos != p) par = par ^ w[pos-1];
      w[p-1] = par;
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [2:0] es, input logic [3:0] ed);
    nchk++;
    if (syndrome !== es) begin
      nfail++;
      $display("FAIL %s syndrome: got %b expected %b", name, syndrome, es);
    end
    nchk++;
    if (data !== ed) begin
      nfail++;
      $display("FAIL %s data: got %b expected %b", name, data, ed);
    end
  endtask

  // Drive one codeword, let one edge sample it, look just after the edge
  task automatic apply(input logic [6:0] cw);
    codeword = cw;
    @(posedge clk);
    #1;
`ifdef HAMMING_ERR_COUNT_EN
    if (rst_n && ref_syn(cw) != 0 && exp_cnt < 65535) exp_cnt++;
`endif
  endtask

  task automatic apply_chk(input string name, input logic [6:0] cw);
    apply(cw);
    chk(name, ref_syn(cw), ref_data(cw));
  endtask

`ifdef HAMMING_ERR_COUNT_EN
  task automatic chk_cnt(input string name, input int exp);
    nchk++;
    if (err_count !== 16'(exp)) begin
      nfail++;
      $display("FAIL %s err_count: got %0d expected %0d", name, err_count, exp);
    end
  endtask
`endif

  typedef struct {
    logic [6:0] cw;
    logic [2:0] syn;
    logic [3:0] dat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{7'b0101010, 3'b000, 4'b0100};
    tbl[1] = '{7'b1010101, 3'b000, 4'b1011};
    tbl[2] = '{7'b0011100, 3'b010, 4'b0011};
    tbl[3] = '{7'b1011100, 3'b101, 4'b1001};
    tbl[4] = '{7'b0001010, 3'b110, 4'b0100};
    tbl[5] = '{7'b1010001, 3'b011, 4'b1011};

    // Reset held for two cycles with error-bearing input
    #1;
    rst_n = 1'b0;
    apply(7'b1011100);
    apply(7'b1111111);
    chk("reset", 3'b000, 4'b0000);
`ifdef HAMMING_ERR_COUNT_EN
    chk_cnt("reset", 0);
`endif
    rst_n = 1'b1;

    // Directed table, back-to-back so each result must match its own edge
    for (int i = 0; i < 6; i++) begin
      apply(tbl[i].cw);
      chk($sformatf("table[%0d]", i), tbl[i].syn, tbl[i].dat);
    end

    // Reset in mid-stream discards the in-flight word; decode resumes next edge
    apply_chk("pre_midreset", 7'b1011100);
    rst_n = 1'b0;
    apply(7'b0011100);
    chk("midreset", 3'b000, 4'b0000);
    rst_n = 1'b1;
    apply_chk("post_midreset", 7'b0011100);

    // Exhaustive single-error sweep from a fresh counter
    rst_n = 1'b0;
    apply(7'b0000000);
    rst_n = 1'b1;
`ifdef HAMMING_ERR_COUNT_EN
    exp_cnt = 0;
`endif
    for (int d = 0; d < 16; d++) begin
      logic [6:0] cw;
      cw = ref_encode(4'(d));
      apply(cw);
      chk($sformatf("clean d=%0d", d), 3'b000, 4'(d));
      for (int b = 0; b < 7; b++) begin
        logic [6:0] bad;
        bad = cw;
        bad[b] = ~bad[b];
        apply(bad);
        chk($sformatf("flip d=%0d pos=%0d", d, b + 1), 3'(b + 1), 4'(d));
      end
    end
`ifdef HAMMING_ERR_COUNT_EN
    chk_cnt("sweep", 112);
`endif

    // Random words, including double errors, against the model
    for (int i = 0; i < 200; i++)
      apply_chk($sformatf("rand[%0d]", i), 7'($urandom_range(0, 127)));
`ifdef HAMMING_ERR_COUNT_EN
    chk_cnt("random", exp_cnt);

    // Saturation: preload near the top, then keep feeding errors
    force dut.err_cnt_q = 16'hFFFE;
    codeword = 7'b0000000;
    @(posedge clk);
    #1;
    release dut.err_cnt_q;
    apply(7'b0000001);
    chk_cnt("sat_reach", 65535);
    apply(7'b0000010);
    chk_cnt("sat_hold", 65535);
    apply(7'b1000000);
    chk_cnt("sat_hold2", 65535);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
